// File: rtl/aes_pkg.sv
// Shared AES-128 control definitions: sequencer states, round/key-select sizing
// and the default key-wait limit used by the controller and its neighbours.
package aes_pkg;

  localparam int AES128_ROUNDS   = 10;
  localparam int AES_KEY_SEL_W   = 4;
  localparam int AES_KEY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KREQ,
    ST_KWAIT,
    ST_EXEC,
    ST_DONE,
    ST_FAULT
  } aes_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes_key_wait_timer.sv
// Counts cycles spent waiting for a round key. Cleared when the key is
// requested, advanced while waiting, and flags the last permitted wait cycle.
module aes_key_wait_timer
  import aes_pkg::*;
#(
  parameter int KEY_TIMEOUT = AES_KEY_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_w(KEY_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(KEY_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Wait-cycle counter; saturates on the last permitted cycle so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 block sequencer: accepts one block, walks rounds 0..NUM_ROUNDS by
// requesting each round key and strobing the datapath, then hands the
// ciphertext back. A key that never arrives parks the block in FAULT.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES128_ROUNDS,
  parameter int KEY_TIMEOUT = AES_KEY_TIMEOUT,
  parameter int RW          = AES_KEY_SEL_W
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic          Rnd_Load,
  output logic          Key_En,
  output logic [RW-1:0] Key_Sel,
  input  logic          Key_Ry,
  output logic          Rnd_En,
  output logic          Rnd_First,
  output logic          Rnd_Last,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Busy,
  output logic [RW-1:0] Round,
  output logic          Err
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

  aes_state_e    state, state_nx;
  logic [RW-1:0] round, round_nx;
  logic          tmr_clr, tmr_en, tmr_expired;
  logic          last_round;

  assign last_round = (round == LAST_ROUND);

  aes_key_wait_timer #(
    .KEY_TIMEOUT(KEY_TIMEOUT)
  ) u_key_wait_timer (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // State and round counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      round <= '0;
    end else begin
      state <= state_nx;
      round <= round_nx;
    end
  end

  // Next-state, round update and per-state strobes.
  always_comb begin
    state_nx  = state;
    round_nx  = round;
    In_Ready  = 1'b0;
    Rnd_Load  = 1'b0;
    Key_En    = 1'b0;
    Rnd_En    = 1'b0;
    Rnd_First = 1'b0;
    Rnd_Last  = 1'b0;
    Out_Valid = 1'b0;
    Err       = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        In_Ready = 1'b1;
        Rnd_Load = In_Valid;
        if (In_Valid) begin
          round_nx = '0;
          state_nx = ST_KREQ;
        end
      end
      ST_KREQ: begin
        Key_En   = 1'b1;
        tmr_clr  = 1'b1;
        state_nx = ST_KWAIT;
      end
      ST_KWAIT: begin
        tmr_en = 1'b1;
        // A key arriving on the last permitted cycle still counts.
        if (Key_Ry) begin
          state_nx = ST_EXEC;
        end else if (tmr_expired) begin
          state_nx = ST_FAULT;
        end
      end
      ST_EXEC: begin
        Rnd_En    = 1'b1;
        Rnd_First = (round == '0);
        Rnd_Last  = last_round;
        if (last_round) begin
          state_nx = ST_DONE;
        end else begin
          round_nx = round + 1'b1;
          state_nx = ST_KREQ;
        end
      end
      ST_DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          round_nx = '0;
          state_nx = ST_IDLE;
        end
      end
      ST_FAULT: begin
        Err = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        round_nx = '0;
      end
    endcase
  end

  assign Busy    = (state != ST_IDLE);
  assign Key_Sel = round;
  assign Round   = round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed blocks against a key-expansion model,
// with a scoreboard of expected key requests, round strobes and latencies.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int RW = AES_KEY_SEL_W;
  localparam int NR = AES128_ROUNDS;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          In_Valid = 1'b0;
  logic          Key_Ry = 1'b0;
  logic          Out_Ready = 1'b1;
  logic          In_Ready, Rnd_Load, Key_En, Rnd_En, Rnd_First, Rnd_Last;
  logic          Out_Valid, Busy, Err;
  logic [RW-1:0] Key_Sel, Round;

  aes_round_ctrl dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Rnd_Load(Rnd_Load), .Key_En(Key_En), .Key_Sel(Key_Sel), .Key_Ry(Key_Ry),
    .Rnd_En(Rnd_En), .Rnd_First(Rnd_First), .Rnd_Last(Rnd_Last),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Busy(Busy),
    .Round(Round), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int sel;
    bit is_first;
    bit is_last;
  } rnd_exp_t;

  rnd_exp_t rnd_q[$];
  int       key_q[$];
  int       lat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // key model configuration
  int kdelay     = 1;   // cycles from Key_En to Key_Ry; -1 = random 1..8
  bit spurious   = 1'b0;
  int never_sel  = -1;
  int long_sel   = -1;
  int long_delay = 0;

  // monitor state
  bit inflight = 1'b0;
  bit ov_seen  = 1'b0;
  bit waiting  = 1'b0;
  int load_cyc = 0;
  int cur_sel  = 0;

  // free-running cycle count used for latency measurement
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_delay(input int sel);
    if (sel == long_sel) return long_delay;
    if (kdelay < 0) return 1 + int'($urandom_range(0, 7));
    return kdelay;
  endfunction

  task automatic key_model();
    int d;
    forever begin
      @(negedge Clk);
      if (Rst) continue;
      if (spurious && Rnd_En && !Rnd_Last) begin
        d = pick_delay(int'(Round) + 1);
        if (d < 2) d = 2;
        @(posedge Clk); #1 Key_Ry = 1'b1;   // high during KREQ only
        @(posedge Clk); #1 Key_Ry = 1'b0;
        repeat (d - 1) @(posedge Clk);
        #1 Key_Ry = 1'b1;
        @(posedge Clk); #1 Key_Ry = 1'b0;
      end else if (Key_En && int'(Key_Sel) != never_sel) begin
        d = pick_delay(int'(Key_Sel));
        repeat (d) @(posedge Clk);
        #1 Key_Ry = 1'b1;
        @(posedge Clk); #1 Key_Ry = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    rnd_exp_t e;
    int l;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        inflight = 1'b0;
        ov_seen  = 1'b0;
        waiting  = 1'b0;
        continue;
      end
      if (!Rnd_En) check("qualifiers_without_rnd_en", int'({Rnd_First, Rnd_Last}), 0);
      if (Rnd_Load) begin
        inflight = 1'b1;
        ov_seen  = 1'b0;
        load_cyc = cyc;
      end
      if (Key_En) begin
        if (key_q.size() == 0) check("key_en_unexpected", int'(Key_En), 0);
        else check("key_sel_at_key_en", int'(Key_Sel), key_q.pop_front());
        cur_sel = int'(Key_Sel);
        waiting = 1'b1;
      end else if (waiting) begin
        check("key_sel_stable", int'(Key_Sel), cur_sel);
      end
      if (Rnd_En) begin
        if (rnd_q.size() == 0) begin
          check("rnd_en_unexpected", int'(Rnd_En), 0);
        end else begin
          e = rnd_q.pop_front();
          check("rnd_key_sel", int'(Key_Sel), e.sel);
          check("rnd_round", int'(Round), e.sel);
          check("rnd_first", int'(Rnd_First), int'(e.is_first));
          check("rnd_last", int'(Rnd_Last), int'(e.is_last));
        end
        waiting = 1'b0;
      end
      if (Out_Valid) begin
        if (!inflight) begin
          check("out_valid_unexpected", int'(Out_Valid), 0);
        end else if (!ov_seen) begin
          ov_seen = 1'b1;
          check("rounds_done_before_out", rnd_q.size(), 0);
          if (lat_q.size() == 0) begin
            check("out_valid_no_block", int'(Out_Valid), 0);
          end else begin
            l = lat_q.pop_front();
            if (l >= 0) check("latency", cyc - load_cyc, l);
          end
        end
        if (Out_Ready) begin
          inflight = 1'b0;
          ov_seen  = 1'b0;
        end
      end
    end
  endtask

  task automatic push_block(input int lat);
    rnd_exp_t e;
    for (int r = 0; r <= NR; r++) begin
      key_q.push_back(r);
      e.sel      = r;
      e.is_first = (r == 0);
      e.is_last  = (r == NR);
      rnd_q.push_back(e);
    end
    lat_q.push_back(lat);
  endtask

  task automatic send_block(input int lat);
    push_block(lat);
    @(posedge Clk); #1 In_Valid = 1'b1;
    @(negedge Clk);
    check("in_ready_at_handshake", int'(In_Ready), 1);
    check("rnd_load_at_handshake", int'(Rnd_Load), 1);
    @(posedge Clk); #1 In_Valid = 1'b0;
    @(negedge Clk);
    check("rnd_load_once", int'(Rnd_Load), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Busy && n < budget);
    check("idle_reached", int'(Busy), 0);
  endtask

  task automatic wait_key(input int sel, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge Clk);
      if (Key_En && int'(Key_Sel) == sel) hit = 1'b1;
    end
    check("wait_key_en", int'(hit), 1);
  endtask

  task automatic wait_exec(input int sel, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge Clk);
      if (Rnd_En && int'(Key_Sel) == sel) hit = 1'b1;
    end
    check("wait_rnd_en", int'(hit), 1);
  endtask

  task automatic flush();
    key_q.delete();
    rnd_q.delete();
    lat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    fork
      monitor();
      key_model();
    join_none

    // reset then idle
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("rst_in_ready", int'(In_Ready), 1);
      check("rst_busy", int'(Busy), 0);
      check("rst_err", int'(Err), 0);
      check("rst_key_sel", int'(Key_Sel), 0);
      check("rst_round", int'(Round), 0);
      check("rst_strobes", int'({Key_En, Rnd_En, Rnd_Load, Out_Valid}), 0);
    end

    // nominal block, key one cycle after request
    send_block(34);
    wait_idle(100);

    // output backpressure
    Out_Ready = 1'b0;
    send_block(34);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge Clk);
      if (Out_Valid) hit = 1'b1;
    end
    check("bp_out_valid_seen", int'(hit), 1);
    @(posedge Clk);
    #1;
    push_block(34);
    In_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("bp_out_valid_held", int'(Out_Valid), 1);
      check("bp_in_ready_low", int'(In_Ready), 0);
      check("bp_no_load", int'(Rnd_Load), 0);
      @(posedge Clk);
      #1;
    end
    Out_Ready = 1'b1;
    @(negedge Clk);
    check("bp_handshake_out_valid", int'(Out_Valid), 1);
    check("bp_handshake_in_ready", int'(In_Ready), 0);
    check("bp_handshake_no_load", int'(Rnd_Load), 0);
    @(negedge Clk);
    check("bp_accept_in_ready", int'(In_Ready), 1);
    check("bp_accept_load", int'(Rnd_Load), 1);
    @(posedge Clk); #1 In_Valid = 1'b0;
    wait_idle(100);

    // variable key latency
    kdelay = -1;
    repeat (3) begin
      send_block(-1);
      wait_idle(300);
    end

    // Key_Ry pulsed during KREQ is ignored
    spurious = 1'b1;
    kdelay   = 2;
    send_block(45);
    wait_idle(200);
    kdelay = -1;
    send_block(-1);
    wait_idle(300);
    spurious = 1'b0;
    kdelay   = 1;

    // key on the last permitted wait cycle still executes
    long_sel   = 3;
    long_delay = 16;
    send_block(49);
    wait_idle(200);
    check("late_key_no_err", int'(Err), 0);
    long_sel = -1;

    // key timeout in round 3
    never_sel = 3;
    send_block(-1);
    wait_key(3, 100);
    for (int i = 1; i <= 16; i++) begin
      @(negedge Clk);
      check("kwait_no_err", int'(Err), 0);
    end
    @(negedge Clk);
    check("fault_err", int'(Err), 1);
    check("fault_round", int'(Round), 3);
    check("fault_in_ready", int'(In_Ready), 0);
    check("fault_busy", int'(Busy), 1);
    check("fault_keys_left", key_q.size(), 7);
    check("fault_rounds_left", rnd_q.size(), 8);
    @(posedge Clk);
    #1 In_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Out_Ready = i[0];
      @(negedge Clk);
      check("fault_sticky", int'(Err), 1);
      check("fault_no_strobes", int'({Key_En, Rnd_En, Rnd_Load, Out_Valid}), 0);
      @(posedge Clk);
      #1;
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    check("fault_rounds_still_left", rnd_q.size(), 8);
    Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    check("fault_rst_err", int'(Err), 0);
    check("fault_rst_busy", int'(Busy), 0);
    check("fault_rst_round", int'(Round), 0);
    check("fault_rst_in_ready", int'(In_Ready), 1);
    flush();
    never_sel = -1;

    // reset during round 5 execute
    send_block(-1);
    wait_exec(5, 100);
    #1 Rst = 1'b1;
    @(negedge Clk);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_round", int'(Round), 0);
    check("midrst_key_sel", int'(Key_Sel), 0);
    check("midrst_out_valid", int'(Out_Valid), 0);
    #1 Rst = 1'b0;
    flush();
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      check("midrst_quiet", int'({Busy, Out_Valid, Key_En, Rnd_En}), 0);
    end
    send_block(34);
    wait_idle(100);

    repeat (3) @(negedge Clk);
    check("final_queues_empty", key_q.size() + rnd_q.size() + lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
